// File: rtl/gray_blur_3x3.sv
// 3x3 Gaussian blur over a raster-order luminance stream, with two line buffers and a valid-tagged 3-stage pipeline.
// Output is the window centred one row and one column behind the input sample; borders and bypass pass the centre through.
module gray_blur_3x3 #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int DATA_W  = 8,
    parameter int COORD_W = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_pix,
    input  logic [COORD_W-1:0] in_row,
    input  logic [COORD_W-1:0] in_col,
    input  logic               blur_en,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_pix,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col
);

    localparam int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SUM_W  = DATA_W + 4;

    logic [DATA_W-1:0]  lb1 [IMG_W];
    logic [DATA_W-1:0]  lb2 [IMG_W];
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  lb1_rd;
    logic [DATA_W-1:0]  lb2_rd;
    logic               in_range;
    logic               accept;

    // win[row][col]: row 0 = oldest line, col 2 = newest column
    logic [DATA_W-1:0]  win [3][3];
    logic               v1;
    logic [COORD_W-1:0] row1;
    logic [COORD_W-1:0] col1;
    logic               byp1;

    logic [SUM_W-1:0]   sum_c;
    logic               v2;
    logic [SUM_W-1:0]   sum2;
    logic [DATA_W-1:0]  ctr2;
    logic [COORD_W-1:0] row2;
    logic [COORD_W-1:0] col2;
    logic               byp2;

    assign addr     = in_col[ADDR_W-1:0];
    assign in_range = (in_row < COORD_W'(IMG_H)) && (in_col < COORD_W'(IMG_W));
    assign accept   = in_valid && in_range;
    assign lb1_rd   = lb1[addr];
    assign lb2_rd   = lb2[addr];

    // Line buffers carry no reset; stale contents are masked by the border bypass.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[addr] <= lb1_rd;
            lb1[addr] <= in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            v1   <= 1'b0;
            row1 <= '0;
            col1 <= '0;
            byp1 <= 1'b0;
        end else begin
            v1 <= accept && (in_row != '0) && (in_col != '0);
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= in_pix;
                row1      <= in_row - COORD_W'(1);
                col1      <= in_col - COORD_W'(1);
                byp1      <= !blur_en || (in_row == COORD_W'(1)) || (in_col == COORD_W'(1));
            end
        end
    end

    // Kernel weights are powers of two: 1 on corners, 2 on edges, 4 at centre.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_c = sum_c + (SUM_W'(win[i][j]) << ((i == 1 ? 1 : 0) + (j == 1 ? 1 : 0)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            sum2 <= '0;
            ctr2 <= '0;
            row2 <= '0;
            col2 <= '0;
            byp2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sum2 <= sum_c;
                ctr2 <= win[1][1];
                row2 <= row1;
                col2 <= col1;
                byp2 <= byp1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_pix   <= '0;
            o_row   <= '0;
            o_col   <= '0;
        end else begin
            o_valid <= v2;
            if (v2) begin
                o_pix <= byp2 ? ctr2 : sum2[SUM_W-1:4];
                o_row <= row2;
                o_col <= col2;
            end
        end
    end

endmodule

// File: tb/tb_gray_blur_3x3.sv
// Randomized self-checking bench for gray_blur_3x3 on a reduced frame size.
// A frame-array reference computes each expected output from the kernel definition and its due cycle.
module tb_gray_blur_3x3;

    localparam int W  = 16;
    localparam int H  = 14;
    localparam int DW = 8;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pix = '0;
    logic [CW-1:0] in_row = '0;
    logic [CW-1:0] in_col = '0;
    logic          blur_en = 1'b1;
    logic          o_valid;
    logic [DW-1:0] o_pix;
    logic [CW-1:0] o_row;
    logic [CW-1:0] o_col;

    gray_blur_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .COORD_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_pix   (in_pix),
        .in_row   (in_row),
        .in_col   (in_col),
        .blur_en  (blur_en),
        .o_valid  (o_valid),
        .o_pix    (o_pix),
        .o_row    (o_row),
        .o_col    (o_col)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {int cyc; int pix; int row; int col; bit chk;} exp_t;
    typedef struct {int pix; int row; int col;} rec_t;

    int   src  [H][W];
    bit   blr  [H][W];
    int   img  [H][W];
    int   seen [H][W];
    exp_t q[$];
    rec_t rec[$];
    rec_t rec0[$];

    bit mon_en = 1'b0;
    bit hold_known = 1'b1;
    int last_pix = 0, last_row = 0, last_col = 0;

    // Expected output for input sample (r,c): centre (r-1,c-1) weighted over the current frame image.
    function automatic int model_pix(int r, int c, bit be);
        int cr = r - 1;
        int cc = c - 1;
        int s = 0;
        if (!be || cr == 0 || cc == 0) return img[cr][cc];
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * img[cr+dr][cc+dc];
        return s / 16;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && rst_n) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                chk_eq("missed_slot", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk_eq("out_valid", int'(o_valid), 1);
                if (e.chk) begin
                    chk_eq("out_pix", int'(o_pix), e.pix);
                    chk_eq("out_row", int'(o_row), e.row);
                    chk_eq("out_col", int'(o_col), e.col);
                end
                last_pix = e.pix; last_row = e.row; last_col = e.col;
                hold_known = e.chk;
            end else begin
                chk_eq("idle_valid", int'(o_valid), 0);
                if (hold_known) begin
                    chk_eq("hold_pix", int'(o_pix), last_pix);
                    chk_eq("hold_row", int'(o_row), last_row);
                    chk_eq("hold_col", int'(o_col), last_col);
                end
            end
            if (o_valid === 1'b1) begin
                rec.push_back('{int'(o_pix), int'(o_row), int'(o_col)});
                if (o_row < H && o_col < W) seen[o_row][o_col] = int'(o_pix);
            end
        end
    end

    task automatic idle_cyc();
        in_valid = 1'b0;
        in_pix   = DW'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic drive_pix(input int r, input int c, input int pix, input bit be, input bit chkf);
        in_valid = 1'b1;
        in_pix   = DW'(pix);
        in_row   = CW'(r);
        in_col   = CW'(c);
        blur_en  = be;
        img[r][c] = pix;
        if (r > 0 && c > 0) q.push_back('{cyc + 3, model_pix(r, c, be), r - 1, c - 1, chkf});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_now_valid", int'(o_valid), 0);
        chk_eq("rst_now_pix", int'(o_pix), 0);
        chk_eq("rst_now_row", int'(o_row), 0);
        chk_eq("rst_now_col", int'(o_col), 0);
        mon_en = 1'b0;
        q.delete();
        last_pix = 0; last_row = 0; last_col = 0;
        hold_known = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // bmode: 0 bypass, 1 blur, 2 per-pixel blur_en from blr[][]
    task automatic run_frame(input int gap_pct, input int bmode, input bit chkf, input int rst_r, input int rst_c);
        bit be;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rst_r && c == rst_c) begin
                    do_reset();
                    return;
                end
                while (int'($urandom_range(99)) < gap_pct) idle_cyc();
                be = (bmode == 2) ? blr[r][c] : (bmode == 1);
                drive_pix(r, c, src[r][c], be, chkf);
            end
        end
        in_valid = 1'b0;
        repeat (6) idle_cyc();
    endtask

    task automatic fill(input int kind, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0: src[r][c] = val;
                    1: src[r][c] = (r == 10 && c == 10) ? val : 0;
                    2: src[r][c] = c;
                    default: src[r][c] = int'($urandom_range(255));
                endcase
                blr[r][c] = 1'($urandom);
                seen[r][c] = -1;
            end
        rec.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_valid", int'(o_valid), 0);
        chk_eq("reset_pix", int'(o_pix), 0);
        chk_eq("reset_row", int'(o_row), 0);
        chk_eq("reset_col", int'(o_col), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        fill(0, 100);
        run_frame(0, 1, 1, -1, -1);
        chk_eq("const_first", seen[0][0], 100);
        chk_eq("const_inner", seen[6][7], 100);

        fill(1, 160);
        run_frame(0, 1, 1, -1, -1);
        chk_eq("imp_centre", seen[10][10], 40);
        chk_eq("imp_up", seen[9][10], 20);
        chk_eq("imp_down", seen[11][10], 20);
        chk_eq("imp_left", seen[10][9], 20);
        chk_eq("imp_right", seen[10][11], 20);
        chk_eq("imp_diag", seen[9][9], 10);
        chk_eq("imp_diag2", seen[11][11], 10);
        chk_eq("imp_far", seen[5][5], 0);

        fill(1, 15);
        run_frame(0, 1, 1, -1, -1);
        chk_eq("imp15_centre", seen[10][10], 3);

        fill(1, 160);
        run_frame(0, 0, 1, -1, -1);
        chk_eq("byp_centre", seen[10][10], 160);
        chk_eq("byp_up", seen[9][10], 0);
        chk_eq("byp_diag", seen[11][11], 0);

        fill(2, 0);
        run_frame(0, 1, 1, -1, -1);
        chk_eq("ramp_row0", seen[0][5], 5);
        chk_eq("ramp_col0", seen[4][0], 0);
        chk_eq("ramp_inner", seen[7][9], 9);

        fill(3, 0);
        run_frame(0, 1, 1, -1, -1);
        rec0 = rec;
        rec.delete();
        run_frame(30, 1, 1, -1, -1);
        chk_eq("gap_count", rec.size(), rec0.size());
        for (int i = 0; i < rec0.size() && i < rec.size(); i++) begin
            chk_eq("gap_pix", rec[i].pix, rec0[i].pix);
            chk_eq("gap_row", rec[i].row, rec0[i].row);
            chk_eq("gap_col", rec[i].col, rec0[i].col);
        end

        fill(3, 0);
        run_frame(20, 2, 1, -1, -1);

        fill(3, 0);
        run_frame(10, 1, 1, 7, 8);
        run_frame(0, 1, 0, -1, -1);
        fill(3, 0);
        run_frame(20, 1, 1, -1, -1);

        chk_eq("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
